stream_accumulator: RTL and testbench

Frame-based streaming accumulator that sits directly downstream of the team's combinational `ripple_carry_adder`. It instantiates that adder to sum COUNT consecutive input words into one running total, and tracks a sticky carry-out as an overflow flag. It presents the finished frame sum on a valid/ready output port. This turns the purely combinational adder into a handshaked, clocked datapath stage for the rest of the design.

---
 rtl/accum_pkg.sv | 5 +
 rtl/ripple_carry_adder.sv | 19 +
 rtl/stream_accumulator.sv | 75 +++++++
 tb/tb_stream_accumulator.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared types and limits for the frame-based stream accumulator.
package accum_pkg;
  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_e;
  localparam int COUNT_MAX = 255;
endpackage

// File: rtl/ripple_carry_adder.sv
// Combinational ripple-carry adder, one generated full-adder cell per bit.
module ripple_carry_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] w_c;

  assign w_c[0] = cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]    = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1]  = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end
  assign cout = w_c[WIDTH];
endmodule

// File: rtl/stream_accumulator.sv
// Sums COUNT accepted input words per frame and presents the total plus a
// sticky carry-out flag on a valid/ready output port.
module stream_accumulator
  import accum_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf
);
  localparam int            CW   = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  if (COUNT < 1 || COUNT > COUNT_MAX) begin : g_bad_count
    $error("stream_accumulator: COUNT out of range");
  end

  state_e           r_state, w_next;
  logic [WIDTH-1:0] r_acc, w_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf, w_cout, w_acc, w_last;

  ripple_carry_adder #(.WIDTH(WIDTH)) u_add (
    .a    (r_acc),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  assign w_acc  = in_valid && in_ready;
  assign w_last = (r_cnt == LAST);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ACCUM: if (w_acc && w_last) w_next = HOLD;
      HOLD:  if (out_ready)       w_next = ACCUM;
    endcase
  end

  // clr shares the reset path so an abort drops any beat or handshake in flight
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_acc <= w_sum;
        r_ovf <= r_ovf | w_cout;
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end else if (r_state == HOLD && out_ready) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
      end
    end
  end

  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == HOLD);
  assign out_sum   = r_acc;
  assign out_ovf   = r_ovf;
endmodule

// File: tb/tb_stream_accumulator.sv
// Bench for stream_accumulator: directed scenarios plus randomized frames vs a
// beat-list reference model (frame sum = integer total mod 256, ovf = total > 255).
module tb_stream_accumulator;
  localparam int WIDTH = 8;
  localparam int COUNT = 4;

  logic       clk = 1'b0;
  logic       rst, clr, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid, out_ovf;
  logic [7:0] out_sum;

  int passed = 0;
  int total  = 0;

  stream_accumulator #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  // reference model: list of beats in the current frame plus one pending result
  int   beats[$];
  bit   pend    = 1'b0;
  int   exp_sum = 0;
  bit   exp_ovf = 1'b0;
  int   frames  = 0;

  task automatic model_edge();
    if (rst || clr) begin
      beats.delete();
      pend = 1'b0;
    end else if (pend) begin
      if (out_ready) begin
        pend = 1'b0;
        frames++;
      end
    end else if (in_valid) begin
      beats.push_back(int'(in_data));
      if (beats.size() == COUNT) begin
        int s;
        s = 0;
        foreach (beats[i]) s += beats[i];
        exp_sum = s % 256;
        exp_ovf = (s > 255);
        pend    = 1'b1;
        beats.delete();
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input bit r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    total++; if (in_ready !== 1'b1)  $display("FAIL reset_in_ready got=%b exp=1", in_ready);   else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
    total++; if (out_sum !== 8'h00)  $display("FAIL reset_out_sum got=%h exp=00", out_sum);    else passed++;
    total++; if (out_ovf !== 1'b0)   $display("FAIL reset_out_ovf got=%b exp=0", out_ovf);     else passed++;
  endtask

  task automatic test_basic();
    logic [7:0] d[4] = '{8'h10, 8'h20, 8'h30, 8'h40};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, d[i], 1'b1);
      if (i < 3) begin
        total++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid beat=%0d got=%b exp=0", i, out_valid); else passed++;
      end
    end
    total++; if (out_valid !== 1'b1 || out_sum !== 8'hA0 || out_ovf !== 1'b0)
      $display("FAIL basic_result got v=%b s=%h o=%b exp v=1 s=a0 o=0", out_valid, out_sum, out_ovf); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL basic_in_ready_hold got=%b exp=0", in_ready); else passed++;
    drive(1'b0, 8'h00, 1'b1);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL basic_one_cycle got v=%b r=%b exp v=0 r=1", out_valid, in_ready); else passed++;
  endtask

  task automatic test_overflow();
    logic [7:0] d[4] = '{8'hFF, 8'h01, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) drive(1'b1, d[i], 1'b0);
    total++; if (out_valid !== 1'b1 || out_sum !== 8'h00 || out_ovf !== 1'b1)
      $display("FAIL ovf_result got v=%b s=%h o=%b exp v=1 s=00 o=1", out_valid, out_sum, out_ovf); else passed++;
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h01, 1'b0);
    total++; if (out_valid !== 1'b1 || out_sum !== 8'h04 || out_ovf !== 1'b0)
      $display("FAIL ovf_cleared got v=%b s=%h o=%b exp v=1 s=04 o=0", out_valid, out_sum, out_ovf); else passed++;
    drive(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [7:0] d[4] = '{8'h3C, 8'h5A, 8'h01, 8'h01};
    for (int i = 0; i < 4; i++) drive(1'b1, d[i], 1'b0);
    for (int i = 0; i < 5; i++) begin
      total++; if (out_valid !== 1'b1 || out_sum !== 8'h98 || out_ovf !== 1'b0 || in_ready !== 1'b0)
        $display("FAIL bp_hold cyc=%0d got v=%b s=%h o=%b r=%b exp v=1 s=98 o=0 r=0",
                 i, out_valid, out_sum, out_ovf, in_ready); else passed++;
      drive(1'b1, 8'hEE, 1'b0);
    end
    drive(1'b0, 8'h00, 1'b1);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_release got v=%b r=%b exp v=0 r=1", out_valid, in_ready); else passed++;
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h02, 1'b0);
    total++; if (out_valid !== 1'b1 || out_sum !== 8'h08)
      $display("FAIL bp_no_leak got v=%b s=%h exp v=1 s=08", out_valid, out_sum); else passed++;
    drive(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_gaps();
    bit v[7] = '{1, 0, 1, 0, 0, 1, 1};
    for (int i = 0; i < 7; i++) begin
      drive(v[i], v[i] ? 8'h05 : 8'hA5, 1'b0);
      if (i < 6) begin
        total++; if (out_valid !== 1'b0) $display("FAIL gap_early_valid cyc=%0d got=%b exp=0", i, out_valid); else passed++;
      end
    end
    total++; if (out_valid !== 1'b1 || out_sum !== 8'h14 || out_ovf !== 1'b0)
      $display("FAIL gap_result got v=%b s=%h o=%b exp v=1 s=14 o=0", out_valid, out_sum, out_ovf); else passed++;
    drive(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_abort();
    logic [7:0] d[4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 8'h80, 1'b0);
      drive(1'b1, 8'h80, 1'b0);
      if (k == 0) rst = 1'b1; else clr = 1'b1;
      drive(1'b1, 8'h80, 1'b1);
      rst = 1'b0; clr = 1'b0;
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 8'h00 || out_ovf !== 1'b0)
        $display("FAIL abort_state k=%0d got r=%b v=%b s=%h o=%b exp r=1 v=0 s=00 o=0",
                 k, in_ready, out_valid, out_sum, out_ovf); else passed++;
      for (int i = 0; i < 4; i++) drive(1'b1, d[i], 1'b0);
      total++; if (out_valid !== 1'b1 || out_sum !== 8'h0A || out_ovf !== 1'b0)
        $display("FAIL abort_next k=%0d got v=%b s=%h o=%b exp v=1 s=0a o=0", k, out_valid, out_sum, out_ovf); else passed++;
      // abort while a result is pending and downstream is ready
      clr = 1'b1;
      drive(1'b0, 8'h00, 1'b1);
      clr = 1'b0;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL abort_hold k=%0d got v=%b r=%b exp v=0 r=1", k, out_valid, in_ready); else passed++;
    end
  endtask

  task automatic test_random();
    int target;
    int cyc;
    target = frames + 200;
    cyc = 0;
    while (frames < target && cyc < 20000) begin
      total++; if (in_ready !== !pend || out_valid !== pend)
        $display("FAIL rand_handshake cyc=%0d got r=%b v=%b exp r=%b v=%b", cyc, in_ready, out_valid, !pend, pend);
      else passed++;
      if (pend) begin
        total++; if (out_sum !== 8'(exp_sum) || out_ovf !== exp_ovf)
          $display("FAIL rand_result cyc=%0d got s=%h o=%b exp s=%h o=%b", cyc, out_sum, out_ovf, 8'(exp_sum), exp_ovf);
        else passed++;
      end
      clr = ($urandom_range(63) == 0);
      drive(($urandom_range(2) != 0), 8'($urandom), ($urandom_range(1) != 0));
      clr = 1'b0;
      cyc++;
    end
    total++; if (frames < target) $display("FAIL rand_timeout frames=%0d exp=%0d", frames, target); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_gaps();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
